// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, oversampling ratio and
// default frame format used by both the transmit and receive paths.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_t;

endpackage

// File: rtl/uart_tx_hold.sv
// One-word transmit holding register with occupancy flag; the write-side
// mirror of the receive flag buffer.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] din,
  input  logic            load,
  output logic [DBIT-1:0] hold,
  output logic            full
);

  // A write while occupied is dropped silently; load only occurs while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      full <= 1'b0;
    end else if (wr && !full) begin
      hold <= din;
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter: holding register feeding a start/data/stop serializer
// clocked by a 16x oversampling baud tick.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a held byte
//   ST_START | driving the start bit (low) for OVERSAMPLE ticks
//   ST_DATA  | shifting out DBIT data bits, LSB first
//   ST_STOP  | driving stop bit(s) high for SB_TICK ticks
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] din,
  output logic            full,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  tx_state_t       state;
  logic [4:0]      s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] b_reg;
  logic [DBIT-1:0] hold;
  logic            load;

  assign load = (state == ST_IDLE) && full;

  uart_tx_hold #(.DBIT(DBIT)) u_hold (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .load  (load),
    .hold  (hold),
    .full  (full)
  );

  // tx is registered alongside state so it always shows the bit being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (full) begin
            b_reg   <= hold;
            s_cnt   <= '0;
            state   <= ST_START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_cnt == BIT_LAST) begin
              s_cnt <= '0;
              n_cnt <= '0;
              state <= ST_DATA;
              tx    <= b_reg[0];
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_LAST) begin
              s_cnt <= '0;
              b_reg <= b_reg >> 1;
              if (n_cnt == N_LAST) begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end else begin
                n_cnt <= n_cnt + 3'd1;
                tx    <= b_reg[1];
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (s_cnt == STOP_LAST) begin
              s_cnt        <= '0;
              state        <= ST_IDLE;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: frame timing, back-to-back, overrun,
// tick gating, long stop and reset abort, with an independent line decoder.
module tb_uart_tx_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr, wr2;
  logic [7:0] din, din2;
  logic       full, tx_busy, tx_done_tick, tx;
  logic       full2, tx_busy2, tx_done_tick2, tx2;

  always #5 clk = ~clk;

  uart_tx_buf #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .wr           (wr),
    .din          (din),
    .full         (full),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  uart_tx_buf #(.DBIT(8), .SB_TICK(32)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .wr           (wr2),
    .din          (din2),
    .full         (full2),
    .tx_busy      (tx_busy2),
    .tx_done_tick (tx_done_tick2),
    .tx           (tx2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Baud tick every 4 clk; holding the phase freezes the tick schedule exactly.
  logic tick_hold = 1'b0;
  int   phase = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_hold) s_tick = 1'b0;
      else begin
        phase  = (phase + 1) % 4;
        s_tick = (phase == 0);
      end
    end
  end

  // Line monitor and mid-bit sampling receiver
  int         cyc = 0;
  int         done_cnt = 0, done_cyc = 0;
  int         done2_cnt = 0, done2_cyc = 0, rise2_cyc = 0;
  int         trans[$];
  logic       prev_tx = 1'b1, prev_tx2 = 1'b1;
  bit         rx_en = 1'b1, rx_busy = 1'b0;
  int         rx_cnt = 0, rx_bad = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_done_tick === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (tx !== prev_tx) trans.push_back(cyc);
    if (tx_done_tick2 === 1'b1) begin done2_cnt++; done2_cyc = cyc; end
    if (prev_tx2 === 1'b0 && tx2 === 1'b1) rise2_cyc = cyc;
    if (!rx_en) rx_busy = 1'b0;
    else if (!rx_busy) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt == 32 && tx !== 1'b0) rx_bad++;
      if (rx_cnt >= 96 && rx_cnt <= 96 + 64*7 && (rx_cnt - 96) % 64 == 0)
        rx_sh = {tx, rx_sh[7:1]};
      if (rx_cnt == 96 + 64*8) begin
        if (tx !== 1'b1) rx_bad++;
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end
    prev_tx  = tx;
    prev_tx2 = tx2;
  end

  task automatic send(input logic [7:0] b);
    din = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
  endtask

  int d0, dc1, f, w, sz;

  initial begin
    reset = 1'b1; wr = 1'b0; din = '0; wr2 = 1'b0; din2 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_full", full, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_tx2", tx2, 1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    trans.delete(); rx_q.delete();

    // Single frame 0x55
    d0 = done_cnt;
    send(8'h55);
    check("t1_full_set", full, 1);
    check("t1_idle_busy", tx_busy, 0);
    @(negedge clk);
    check("t1_full_clr", full, 0);
    check("t1_start_low", tx, 0);
    check("t1_busy", tx_busy, 1);
    wait_done(d0 + 1, 1000);
    repeat (5) @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_busy_end", tx_busy, 0);
    sz = trans.size();
    check("t1_edges", sz, 10);
    if (sz == 10) begin
      w = trans[1] - trans[0];
      check("t1_start_len", (w >= 61 && w <= 64), 1);
      for (int k = 1; k <= 8; k++) check($sformatf("t1_bit%0d_len", k - 1), trans[k+1] - trans[k], 64);
      check("t1_stop_len", done_cyc - trans[9], 64);
    end
    check("t1_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t1_rx_byte", rx_q[0], 8'h55);

    // Back-to-back 0xA3 then 0x0F
    trans.delete(); rx_q.delete(); rx_bad = 0;
    d0 = done_cnt;
    send(8'hA3);
    for (int i = 0; i < 100 && full !== 1'b0; i++) @(negedge clk);
    check("t2_load", full, 0);
    send(8'h0F);
    check("t2_full2", full, 1);
    wait_done(d0 + 1, 1500);
    dc1 = done_cyc;
    wait_done(d0 + 2, 1500);
    f = 0;
    foreach (trans[k]) if (f == 0 && trans[k] > dc1) f = trans[k];
    check("t2_gap", f - dc1, 1);
    for (int i = 0; i < 100 && rx_q.size() < 2; i++) @(negedge clk);
    check("t2_rx_cnt", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("t2_rx0", rx_q[0], 8'hA3);
      check("t2_rx1", rx_q[1], 8'h0F);
    end
    check("t2_rx_frame", rx_bad, 0);

    // Overrun: second write lands while full=1 (the load cycle)
    rx_q.delete();
    d0 = done_cnt;
    din = 8'h11; wr = 1'b1;
    @(negedge clk);
    din = 8'h22;
    @(negedge clk);
    wr = 1'b0;
    check("t3_full", full, 0);
    wait_done(d0 + 1, 1000);
    repeat (800) @(negedge clk);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t3_rx_byte", rx_q[0], 8'h11);

    // Tick gating during data bit 2
    rx_en = 1'b0; trans.delete();
    d0 = done_cnt;
    send(8'h55);
    for (int i = 0; i < 400 && trans.size() < 4; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    w = int'(tx);
    @(posedge clk); tick_hold = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    check("t4_tx_frozen", tx, w);
    check("t4_busy_frozen", tx_busy, 1);
    check("t4_no_edge", trans.size(), 4);
    @(posedge clk); tick_hold = 1'b0;
    wait_done(d0 + 1, 1500);
    repeat (5) @(negedge clk);
    sz = trans.size();
    check("t4_edges", sz, 10);
    if (sz == 10) begin
      check("t4_bit2_len", trans[4] - trans[3], 164);
      check("t4_bit3_len", trans[5] - trans[4], 64);
      check("t4_stop_len", done_cyc - trans[9], 64);
    end
    rx_en = 1'b1;

    // 2 stop bits: 0xFF, line high from bit0 start through stop
    d0 = done2_cnt;
    din2 = 8'hFF; wr2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    for (int i = 0; i < 2000 && done2_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t5_done2", done2_cnt - d0, 1);
    check("t5_high_len", done2_cyc - rise2_cyc, 8*64 + 128);
    check("t5_busy2", tx_busy2, 0);

    // Reset mid-frame with a second byte held
    rx_en = 1'b0;
    d0 = done_cnt;
    send(8'h5A);
    repeat (200) @(negedge clk);
    send(8'hC3);
    check("t6_held", full, 1);
    check("t6_busy", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_tx", tx, 1);
    check("t6_full", full, 0);
    check("t6_busy_clr", tx_busy, 0);
    sz = trans.size();
    repeat (1500) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_line_quiet", trans.size() - sz, 0);
    check("t6_tx_idle", tx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
UART transmitter with a one-word transmit holding register. It is the send-side counterpart of the receive path and its receive flag buffer.
- Host writes a byte with a single-cycle `wr` strobe while `full`=0.
- The serializer drains the holding register into a framed serial stream on `tx`: 1 start bit, DBIT data bits LSB first, stop bit(s).
- Bit timing comes from the shared oversampling baud tick `s_tick` (16 ticks per bit).

Parameters:
- DBIT, 8, number of data bits per frame (supported: 5..8).
- SB_TICK, 16, stop-bit duration in s_tick counts (16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
- s_tick, input, 1, baud oversampling tick; one-clk pulse, 16 per bit period.
- wr, input, 1, write strobe; captures `din` into the holding register when `full`=0.
- din, input, DBIT, byte to transmit.
- full, output, 1, holding register occupied; a `wr` while full=1 is ignored.
- tx_busy, output, 1, serializer is in start, data or stop state.
- tx_done_tick, output, 1, one-clk pulse at the end of the stop bit.
- tx, output, 1, serial line; idles high; registered (glitch-free).

Behaviour:
- Reset (synchronous, active-high):
  - Values after the first clk edge with reset=1: state=idle, full=0, tx=1, tx_busy=0, tx_done_tick=0, tick/bit counters=0, holding register=0.
  - Reset mid-frame aborts the frame and discards the held byte.
  - tx returns high on that same edge.
- Holding register:
  - wr=1 and full=0: hold<=din, full<=1 on the next edge.
  - wr=1 and full=1: no effect; the byte is dropped and no error flag is raised.
- Serializer FSM states: idle, start, data, stop.
  - State and tx register update on the same edge; tx reflects the bit of the state being entered.
- idle:
  - tx=1.
  - If full=1: load shift register from hold, clear full, s_cnt<=0, enter start with tx<=0.
  - A wr in that same load cycle is ignored, because full is still 1.
- start:
  - On s_tick, if s_cnt=15: s_cnt<=0, n_cnt<=0, enter data with tx<=b[0].
  - Otherwise, on s_tick: s_cnt++.
  - Clock edges without s_tick hold all state.
- data:
  - On s_tick, if s_cnt=15: s_cnt<=0 and shift b right.
  - If n_cnt=DBIT-1: enter stop with tx<=1; otherwise n_cnt++ and tx<=next bit.
  - Otherwise, on s_tick: s_cnt++.
- stop:
  - On s_tick, if s_cnt=SB_TICK-1: tx_done_tick=1 for that cycle, enter idle.
  - Otherwise, on s_tick: s_cnt++.
- Back-to-back frames:
  - With full=1 when stop ends, idle lasts exactly one clk, then the load happens.
  - No extra line-idle bit is inserted beyond the stop bit(s).
- Bit timing: start and data bits each last exactly 16 s_tick periods; stop lasts SB_TICK periods.
- Counter widths: s_cnt 5 bits (covers SB_TICK up to 32); n_cnt 3 bits.
- tx_busy=1 in start/data/stop, 0 in idle.
- Host may write the next byte as soon as the load clears full, i.e. during the current frame.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (idle, start, data, stop; 2-bit).
  - OVERSAMPLE=16 constant.
  - Default DBIT/SB_TICK values, shared with the receiver.
- One natural sub-module, uart_tx_hold: the holding register plus `full` flag.
  - Ports: set on wr&!full, clear on load.
  - It is the write-side mirror of the receive flag buffer.
- The FSM and shift register stay in the top-level module.

Test Plan:
- Reset mid-frame: assert reset during a data bit -> next edge tx=1, full=0, tx_busy=0; no tx_done_tick afterwards.
- Single frame: s_tick every 4 clk, wr with din=0x55 -> full high 1 clk, then start bit low 64 clk, then bits 1,0,1,0,1,0,1,0 (LSB first) at 64 clk each, then stop high 64 clk; tx_done_tick pulses once.
- Back-to-back frames: wr 0xA3, then wr 0x0F once full drops -> second start bit begins exactly 1 clk after the first frame's tx_done_tick; both bytes decode correctly on tx.
- Overrun: wr 0x11, wr 0x22 while full=1 -> only 0x11 and then nothing else transmitted; 0x22 is lost.
- Stop length: SB_TICK=32, send 0xFF -> stop high 128 clk (at 4 clk/tick) before tx_done_tick.
- Tick gating: hold s_tick low for 100 clk mid-bit -> tx, counters and state frozen; resuming s_tick completes the bit with its 16-tick count intact.
